// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit and the decode stage.
// HILO_MULDIV_DIV_EN enables the DIV state and the iterative divider.
package hilo_muldiv_pkg;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef HILO_MULDIV_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_FIX  = 2'd3
  } state_e;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_sign_fix.sv
// Operand magnitude extraction at acceptance and sign correction of the raw
// unsigned result (product, or remainder:quotient) in the FIX cycle.
module hilo_sign_fix (
  input  logic        signed_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] rs_mag_o,
  output logic [31:0] rt_mag_o,
  input  logic        fix_div_i,
  input  logic        rs_neg_i,
  input  logic        rt_neg_i,
  input  logic [63:0] raw_i,
  output logic [63:0] fix_o
);

  always_comb begin
    rs_mag_o = (signed_i && rs_i[31]) ? -rs_i : rs_i;
    rt_mag_o = (signed_i && rt_i[31]) ? -rt_i : rt_i;
  end

  // rs_neg_i/rt_neg_i are already qualified by the signed flavour of the op.
  always_comb begin
    fix_o = raw_i;
    if (fix_div_i) begin
      if (rs_neg_i ^ rt_neg_i) fix_o[31:0]  = -raw_i[31:0];
      if (rs_neg_i)            fix_o[63:32] = -raw_i[63:32];
    end else if (rs_neg_i ^ rt_neg_i) begin
      fix_o = -raw_i;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// one-cycle sign fix. Divider present only with HILO_MULDIV_DIV_EN defined.
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      acc_q;     // product, or {remainder, quotient/dividend}
  logic [31:0]      opnd_q;    // multiplicand or divisor magnitude
  logic             div_q, rs_neg_q, rt_neg_q;
  logic [31:0]      hi_q, lo_q;
  logic             busy_q, done_q;
  logic [31:0]      rs_mag, rt_mag;
  logic [63:0]      fix_val, result_d;
  logic [32:0]      mul_sum;
  logic [63:0]      mul_next;

  hilo_sign_fix u_sign_fix (
    .signed_i  (op_is_signed(op)),
    .rs_i      (rs_val),
    .rt_i      (rt_val),
    .rs_mag_o  (rs_mag),
    .rt_mag_o  (rt_mag),
    .fix_div_i (div_q),
    .rs_neg_i  (rs_neg_q),
    .rt_neg_i  (rt_neg_q),
    .raw_i     (acc_q),
    .fix_o     (fix_val)
  );

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'h0);
    mul_next = {mul_sum, acc_q[31:1]};
  end

`ifdef HILO_MULDIV_DIV_EN
  logic        div0_q;
  logic [31:0] rs_q;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;

  always_comb begin
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0],  acc_q[30:0], 1'b1};
    result_d  = fix_val;
    if (div_q && div0_q) result_d = {rs_q, 32'hFFFF_FFFF};
  end
`else
  always_comb result_d = fix_val;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      rt_neg_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
      div0_q   <= 1'b0;
      rs_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op_e'(op))
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              OP_MULT, OP_MULTU: begin
                state_q  <= ST_MUL;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                acc_q    <= {32'h0, rt_mag};
                opnd_q   <= rs_mag;
                div_q    <= 1'b0;
                rs_neg_q <= op_is_signed(op) & rs_val[31];
                rt_neg_q <= op_is_signed(op) & rt_val[31];
              end
              OP_DIV, OP_DIVU: begin
`ifdef HILO_MULDIV_DIV_EN
                state_q  <= ST_DIV;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                acc_q    <= {32'h0, rs_mag};
                opnd_q   <= rt_mag;
                div_q    <= 1'b1;
                div0_q   <= (rt_val == 32'h0);
                rs_q     <= rs_val;
                rs_neg_q <= op_is_signed(op) & rs_val[31];
                rt_neg_q <= op_is_signed(op) & rt_val[31];
`else
                done_q   <= 1'b1;
`endif
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_q <= ST_FIX;
        end
`ifdef HILO_MULDIV_DIV_EN
        ST_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_q <= ST_FIX;
        end
`endif
        ST_FIX: begin
          hi_q    <= result_d[63:32];
          lo_q    <= result_d[31:0];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized and directed bench for hilo_muldiv_unit against a plain-arithmetic
// HI/LO model; honours HILO_MULDIV_DIV_EN like the design.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  hilo_muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result {hi, lo} after the op completes.
  function automatic logic [63:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb;
    int                 ia, ib;
    case (f)
      OP_MULT: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
      end
      OP_MULTU: return {32'h0, a} * {32'h0, b};
`ifdef HILO_MULDIV_DIV_EN
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ia = a;
        ib = b;
        return {32'(ia % ib), 32'(ia / ib)};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
`endif
      default: return {m_hi, m_lo};
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; issues the op so the next posedge accepts it.
  // inj_n > 0 attempts an MTLO accepted at edge k+inj_n (must be ignored).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int inj_n);
    int lat = 0;
    int exp_lat = 34;
    bit busy_ok = 1'b1, hold_ok = 1'b1;
    logic [63:0] exp;
`ifndef HILO_MULDIV_DIV_EN
    if (f == OP_DIV || f == OP_DIVU) exp_lat = 1;
`endif
    exp_q.push_back(ref_model(f, a, b));
    start = 1'b1; op = f; rs_val = a; rt_val = b;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if ({hi, lo} !== {m_hi, m_lo}) hold_ok = 1'b0;
      if (inj_n > 0 && n == inj_n - 1) begin
        start = 1'b1; op = OP_MTLO; rs_val = 32'hDEAD_BEEF;
      end
      if (n == inj_n) start = 1'b0;
    end
    start = 1'b0;
    exp = exp_q.pop_front();
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_during_op", {63'h0, busy_ok}, 64'h1);
    check("hilo_held", {63'h0, hold_ok}, 64'h1);
    check("busy_at_done", {63'h0, busy}, 64'h0);
    check("result", {hi, lo}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  // Single-cycle ops: MTHI/MTLO take effect, NONE/reserved do nothing.
  task automatic run_mt(input logic [2:0] f, input logic [31:0] a);
    start = 1'b1; op = f; rs_val = a; rt_val = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (f == OP_MTHI) m_hi = a;
    if (f == OP_MTLO) m_lo = a;
    check("mt_done", {63'h0, done}, 64'h0);
    check("mt_busy", {63'h0, busy}, 64'h0);
    check("mt_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    bit saw_done;
    rst = 1'b0; start = 1'b0; op = OP_NONE; rs_val = '0; rt_val = '0;
    #2 rst = 1'b1;
    #1;
    check("reset_hi", {32'h0, hi}, 64'h0);
    check("reset_lo", {32'h0, lo}, 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_mt(OP_MTHI, 32'h1234_5678);
    check("mthi_dir", {32'h0, hi}, 64'h1234_5678);
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    check("mult_dir", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    check("multu_dir", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(OP_DIVU, 32'h0000_0007, 32'h0000_0000, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 0);
`ifdef HILO_MULDIV_DIV_EN
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    check("div_dir", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'h0000_0007, 32'h0000_0000, 0);
    check("divu0_dir", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
`endif
    run_op(OP_MULTU, 32'h3, 32'h5, 5);
    check("mtlo_ignored", {hi, lo}, 64'h0000_0000_0000_000F);

    // Reset in the middle of a MULT.
    start = 1'b1; op = OP_MULT; rs_val = $urandom; rt_val = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_hilo", {hi, lo}, 64'h0);
    check("midrst_busy", {63'h0, busy}, 64'h0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst_no_done", {63'h0, saw_done}, 64'h0);
    run_op(OP_MULTU, 32'h2, 32'h3, 0);
    check("multu_after_rst", {hi, lo}, 64'h6);

    // Random mix, issued back to back (including in done cycles).
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: run_op(OP_MULT, rand_opnd(), rand_opnd(), 0);
        1: run_op(OP_MULTU, rand_opnd(), rand_opnd(), 0);
        2: run_op(OP_DIV, rand_opnd(), rand_opnd(), 0);
        3: run_op(OP_DIVU, rand_opnd(), rand_opnd(), 0);
        4: run_mt(OP_MTHI, $urandom);
        5: run_mt(OP_MTLO, $urandom);
        6: run_mt(($urandom_range(0, 1) == 0) ? OP_NONE : OP_RSVD, $urandom);
        default: run_op(OP_MULT, rand_opnd(), rand_opnd(), $urandom_range(3, 30));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
